fir4_rr_sched: RTL

Round-robin scheduler and sequencer that shares one serial 4-tap signed averaging-FIR accumulator among NCH input channels. Each channel keeps its own 3-deep tap history. One accepted sample is accumulated over four cycles (current sample plus the channel's three previous samples), then presented on a valid/ready output with its channel tag. It sits between the per-channel sample sources and the downstream consumer of the w+2-bit filter sum. It replaces NCH copies of the parallel fir4 datapath.

---
 rtl/fir4_rr_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/fir4_rr_sched.sv
// Round-robin sequencer sharing one serial 4-tap signed sum across NCH channels.
// Each channel keeps a private 3-deep history; results leave on a valid/ready port.
module fir4_rr_sched #(
  parameter int w   = 16,
  parameter int NCH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*w-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [w+1:0]     s,
  output logic [1:0]       out_ch,
  output logic             busy
);

  localparam int         CW   = (NCH > 2) ? 2 : 1;
  localparam logic [1:0] LAST = 2'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t         state, state_nxt;
  logic [1:0]     rr_ptr, cur_ch, k, gidx;
  logic [w-1:0]   x0, gdata, term;
  logic [w+1:0]   acc;
  logic [w-1:0]   hist [NCH][3];
  logic [NCH-1:0] grant;
  logic           found, accept;
  logic [2:0]     idx;

  function automatic logic [w+1:0] sext(input logic [w-1:0] v);
    return {{2{v[w-1]}}, v};
  endfunction

  // First valid channel scanning upward from rr_ptr, wrapping at NCH.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = {1'b0, rr_ptr} + 3'(i);
      if (idx >= 3'(NCH)) idx = idx - 3'(NCH);
      if (!found && in_valid[idx[CW-1:0]]) begin
        found              = 1'b1;
        gidx               = idx[1:0];
        grant[idx[CW-1:0]] = 1'b1;
      end
    end
  end

  assign in_ready = (state == IDLE) ? grant : '0;
  assign accept   = |(in_valid & in_ready);
  assign gdata    = in_data[int'(gidx)*w +: w];
  assign term     = hist[cur_ch[CW-1:0]][2'(k - 2'd1)];
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = ACC;
      ACC:     if (k == 2'd3)  state_nxt = OUT;
      OUT:     if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      cur_ch    <= '0;
      k         <= '0;
      x0        <= '0;
      acc       <= '0;
      s         <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++)
        for (int unsigned j = 0; j < 3; j++)
          hist[c][j] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x0     <= gdata;
          cur_ch <= gidx;
          acc    <= sext(gdata);
          k      <= 2'd1;
        end
        ACC: begin
          acc <= acc + sext(term);
          if (k == 2'd3) begin
            // History shifts only after the last tap has been read.
            hist[cur_ch[CW-1:0]][2] <= hist[cur_ch[CW-1:0]][1];
            hist[cur_ch[CW-1:0]][1] <= hist[cur_ch[CW-1:0]][0];
            hist[cur_ch[CW-1:0]][0] <= x0;
            s         <= acc + sext(term);
            out_ch    <= cur_ch;
            out_valid <= 1'b1;
          end else begin
            k <= k + 2'd1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          rr_ptr    <= (cur_ch == LAST) ? 2'd0 : cur_ch + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
